// File: rtl/encoder_rr_arbiter_if.sv
// Request/grant bundle between requesting masters
// and the round-robin arbiter.
interface encoder_rr_arbiter_if #(
   parameter int N    = 8,
   parameter int IDXW = 3
);
   logic [N-1:0]    req;
   logic [N-1:0]    gnt;
   logic [IDXW-1:0] gnt_idx;
   logic            gnt_valid;
   logic            timeout;

   modport master (
      output req,
      input  gnt,
      input  gnt_idx,
      input  gnt_valid,
      input  timeout
   );

   modport slave (
      input  req,
      output gnt,
      output gnt_idx,
      output gnt_valid,
      output timeout
   );
endinterface

// File: rtl/encoder_rr_arbiter.sv
// 8-way round-robin arbiter: rotate by pointer, priority
// encode, register one-hot grant plus binary index.
module encoder_rr_arbiter #(
   parameter int N        = 8,
   parameter int IDXW     = 3,
   parameter int MAX_HOLD = 16
) (
   input  logic clk,
   input  logic rst_n,
   encoder_rr_arbiter_if.slave bus
);

   localparam int HW =
      (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
   localparam logic [HW-1:0] HMAX = HW'(MAX_HOLD);

   typedef enum logic {
      IDLE,
      BUSY
   } state_t;

   state_t          state_q;
   logic [IDXW-1:0] ptr_q;
   logic [HW-1:0]   hold_q;
   logic [N-1:0]    gnt_q;
   logic [IDXW-1:0] idx_q;
   logic            vld_q;
   logic            to_q;
   logic [IDXW-1:0] win_d;

   // First set bit at or after p, wrapping; the
   // index adds back p modulo 2**IDXW == N.
   function automatic logic [IDXW-1:0] pick(
      input logic [N-1:0]    r,
      input logic [IDXW-1:0] p
   );
      logic [N-1:0]    rot;
      logic [IDXW-1:0] off;
      rot = N'({r, r} >> p);
      off = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (rot[i]) off = IDXW'(i);
      end
      return p + off;
   endfunction

   // Winner for the current request vector.
   always_comb begin
      win_d = pick(bus.req, ptr_q);
   end

   // Arbitration FSM with registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         hold_q  <= '0;
         gnt_q   <= '0;
         idx_q   <= '0;
         vld_q   <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         to_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (|bus.req) begin
                  gnt_q   <= N'(1) << win_d;
                  idx_q   <= win_d;
                  vld_q   <= 1'b1;
                  ptr_q   <= win_d + IDXW'(1);
                  hold_q  <= HW'(1);
                  state_q <= BUSY;
               end
            end
            BUSY: begin
               if (!bus.req[idx_q]) begin
                  gnt_q   <= '0;
                  idx_q   <= '0;
                  vld_q   <= 1'b0;
                  state_q <= IDLE;
               end else if (MAX_HOLD != 0 &&
                            hold_q == HMAX) begin
                  gnt_q   <= '0;
                  idx_q   <= '0;
                  vld_q   <= 1'b0;
                  to_q    <= 1'b1;
                  state_q <= IDLE;
               end else if (hold_q != '1) begin
                  hold_q <= hold_q + HW'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.gnt_idx   = idx_q;
   assign bus.gnt_valid = vld_q;
   assign bus.timeout   = to_q;

endmodule

// File: tb/tb_encoder_rr_arbiter.sv
// Scoreboard bench for encoder_rr_arbiter: stimulus
// queues per-cycle expectations, monitor checks them.
module tb_encoder_rr_arbiter;

   logic clk;
   logic rst_n;
   int   cyc;
   int   n_chk;
   int   n_err;
   string tag;

   typedef struct {
      int         c;
      logic [7:0] g;
      logic       to;
      string      nm;
   } exp_t;

   exp_t q[$];

   encoder_rr_arbiter_if #(.N(8), .IDXW(3)) arb ();

   encoder_rr_arbiter #(
      .N(8), .IDXW(3), .MAX_HOLD(16)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (arb.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc++;

   function automatic logic [2:0] idx_of(
      input logic [7:0] g
   );
      logic [2:0] r;
      r = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (g[i]) r = 3'(i);
      end
      return r;
   endfunction

   // Monitor: compare every expectation due this cycle.
   always @(negedge clk) begin
      while (q.size() > 0 && q[0].c <= cyc) begin
         exp_t e;
         logic [12:0] act;
         logic [12:0] req_v;
         e = q.pop_front();
         n_chk++;
         act = {arb.gnt, arb.gnt_idx,
                arb.gnt_valid, arb.timeout};
         req_v = {e.g, idx_of(e.g), |e.g, e.to};
         if (e.c < cyc) begin
            n_err++;
            $display("FAIL %s: expectation for cycle %0d missed at cycle %0d",
                     e.nm, e.c, cyc);
         end else if (act !== req_v) begin
            n_err++;
            $display("FAIL %s cyc %0d: got gnt=%h idx=%0d v=%b to=%b, want gnt=%h idx=%0d v=%b to=%b",
                     e.nm, cyc, arb.gnt, arb.gnt_idx,
                     arb.gnt_valid, arb.timeout,
                     e.g, idx_of(e.g), |e.g, e.to);
         end
      end
   end

   // Drive req for the coming edge and queue the
   // outputs expected after that edge.
   task automatic step(
      input logic [7:0] r,
      input logic [7:0] eg,
      input logic       eto
   );
      arb.req = r;
      q.push_back('{cyc + 1, eg, eto, tag});
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] oh;
      cyc   = 0;
      n_chk = 0;
      n_err = 0;
      rst_n = 1'b0;
      arb.req = 8'hFF;

      tag = "reset_hold";
      repeat (3) step(8'hFF, 8'h00, 1'b0);
      rst_n = 1'b1;
      tag = "first_gnt_idx0";
      step(8'hFF, 8'h01, 1'b0);
      tag = "release0";
      step(8'h00, 8'h00, 1'b0);

      tag = "single_req5";
      repeat (4) step(8'h20, 8'h20, 1'b0);
      tag = "drop5";
      step(8'h00, 8'h00, 1'b0);
      step(8'h00, 8'h00, 1'b0);

      tag = "rr_skip5_to0";
      step(8'h21, 8'h01, 1'b0);
      step(8'h21, 8'h01, 1'b0);
      tag = "rr_drop0";
      step(8'h20, 8'h00, 1'b0);
      tag = "rr_next5";
      step(8'h21, 8'h20, 1'b0);
      step(8'h00, 8'h00, 1'b0);

      tag = "wrap7";
      step(8'h80, 8'h80, 1'b0);
      step(8'h00, 8'h00, 1'b0);

      for (int k = 0; k < 9; k++) begin
         oh = 8'h01 << (k % 8);
         tag = $sformatf("all_req_k%0d", k);
         step(8'hFF, oh, 1'b0);
         step(8'hFF, oh, 1'b0);
         step(8'hFF & ~oh, 8'h00, 1'b0);
      end

      for (int k = 0; k < 2; k++) begin
         tag = $sformatf("hold3_r%0d", k);
         repeat (16) step(8'h08, 8'h08, 1'b0);
         tag = $sformatf("timeout3_r%0d", k);
         step(8'h08, 8'h00, 1'b1);
      end
      tag = "regrant3";
      step(8'h08, 8'h08, 1'b0);
      step(8'h00, 8'h00, 1'b0);

      tag = "hold_sim";
      repeat (16) step(8'h08, 8'h08, 1'b0);
      tag = "drop_at_max";
      step(8'h00, 8'h00, 1'b0);
      step(8'h00, 8'h00, 1'b0);

      tag = "pre_async";
      step(8'h08, 8'h08, 1'b0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      tag = "async_clear";
      q.push_back('{cyc, 8'h00, 1'b0, tag});
      @(posedge clk);
      #1;
      tag = "in_reset";
      step(8'h80, 8'h00, 1'b0);
      rst_n = 1'b1;
      tag = "ptr_reset";
      step(8'h18, 8'h08, 1'b0);
      step(8'h00, 8'h00, 1'b0);
      tag = "post_rst7";
      step(8'h80, 8'h80, 1'b0);
      step(8'h00, 8'h00, 1'b0);

      for (int w = 0; w < 20 && q.size() > 0; w++) begin
         @(posedge clk);
      end
      if (q.size() > 0) begin
         n_chk++;
         n_err++;
         $display("FAIL drain: %0d expectations left, want 0",
                  q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_err);
      $finish;
   end

endmodule
